// File: rtl/dyn_phase_sweep.sv
// Automatic PLL phase calibration: sweeps the selected output counter across NSTEPS
// positions, finds the longest contiguous passing run, then steps back to its centre.
module dyn_phase_sweep #(
   parameter int unsigned NSTEPS      = 16,
   parameter int unsigned SETTLE      = 32,
   parameter int unsigned WINDOW      = 64,
   parameter int unsigned ACK_TIMEOUT = 1024,
   parameter logic [3:0]  CNTSEL      = 4'h2
) (
   input  logic       CLK50M,
   input  logic       RESET_N,
   input  logic       START,
   input  logic       ABORT,
   input  logic       CMP_OK,
   output logic       STEP_REQ,
   output logic       STEP_UP,
   output logic [3:0] STEP_CNTSEL,
   input  logic       STEP_ACK,
   output logic       BUSY,
   output logic       DONE,
   output logic       FAIL,
   output logic [5:0] BEST_START,
   output logic [6:0] BEST_LEN,
   output logic [5:0] POS
);

   localparam int unsigned MAX_SW = (SETTLE > WINDOW) ? SETTLE : WINDOW;
   localparam int unsigned MAX_T  = (ACK_TIMEOUT > MAX_SW) ? ACK_TIMEOUT : MAX_SW;
   localparam int unsigned CNT_W  = $clog2(MAX_T + 1);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [5:0]       POS_LAST    = 6'(NSTEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_EVAL,
      S_STEP,
      S_CALC,
      S_STEP_DN
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             win_ok_q, win_ok_d;
   logic [5:0]       pos_q, pos_d;
   logic [5:0]       cur_start_q, cur_start_d;
   logic [6:0]       cur_len_q, cur_len_d;
   logic [5:0]       best_start_q, best_start_d;
   logic [6:0]       best_len_q, best_len_d;
   logic [5:0]       target_q, target_d;
   logic             req_q, req_d;
   logic             up_q, up_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fail_q, fail_d;

   logic [5:0]       run_start;
   logic [6:0]       run_len;

   always_ff @(posedge CLK50M or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         win_ok_q     <= 1'b0;
         pos_q        <= '0;
         cur_start_q  <= '0;
         cur_len_q    <= '0;
         best_start_q <= '0;
         best_len_q   <= '0;
         target_q     <= '0;
         req_q        <= 1'b0;
         up_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         win_ok_q     <= win_ok_d;
         pos_q        <= pos_d;
         cur_start_q  <= cur_start_d;
         cur_len_q    <= cur_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
         target_q     <= target_d;
         req_q        <= req_d;
         up_q         <= up_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      win_ok_d     = win_ok_q;
      pos_d        = pos_q;
      cur_start_d  = cur_start_q;
      cur_len_d    = cur_len_q;
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
      target_d     = target_q;
      req_d        = req_q;
      up_d         = up_q;
      busy_d       = busy_q;
      done_d       = done_q;
      fail_d       = fail_q;
      run_start    = cur_start_q;
      run_len      = cur_len_q;

      case (state_q)
         S_IDLE: begin
            if (START && !ABORT) begin
               done_d       = 1'b0;
               fail_d       = 1'b0;
               best_start_d = '0;
               best_len_d   = '0;
               pos_d        = '0;
               cur_start_d  = '0;
               cur_len_d    = '0;
               busy_d       = 1'b1;
               cnt_d        = '0;
               state_d      = S_SETTLE;
            end
         end

         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d    = '0;
               win_ok_d = 1'b1;
               state_d  = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_SAMPLE: begin
            win_ok_d = win_ok_q & CMP_OK;
            if (cnt_q == WINDOW_LAST) begin
               cnt_d   = '0;
               state_d = S_EVAL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_EVAL: begin
            if (win_ok_q) begin
               run_start   = (cur_len_q == '0) ? pos_q : cur_start_q;
               run_len     = cur_len_q + 7'd1;
               cur_start_d = run_start;
               cur_len_d   = run_len;
               // Strict compare keeps the earliest run on a tie.
               if (run_len > best_len_q) begin
                  best_start_d = run_start;
                  best_len_d   = run_len;
               end
            end else begin
               cur_len_d = '0;
            end
            if (pos_q < POS_LAST) begin
               req_d   = 1'b1;
               up_d    = 1'b1;
               cnt_d   = '0;
               state_d = S_STEP;
            end else begin
               state_d = S_CALC;
            end
         end

         S_STEP: begin
            if (STEP_ACK) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               pos_d   = up_q ? (pos_q + 6'd1) : (pos_q - 6'd1);
               state_d = up_q ? S_SETTLE : S_STEP_DN;
            end else if (cnt_q == ACK_LAST) begin
               req_d   = 1'b0;
               fail_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_CALC: begin
            if (best_len_q == '0) begin
               fail_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               target_d = best_start_q + 6'(best_len_q >> 1);
               state_d  = S_STEP_DN;
            end
         end

         S_STEP_DN: begin
            // Passing through here between down steps guarantees REQ drops for a cycle.
            if (pos_q == target_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               req_d   = 1'b1;
               up_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_STEP;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides everything except a coincident ACK's position update.
      if (ABORT && (state_q != S_IDLE)) begin
         req_d   = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         fail_d  = 1'b1;
         cnt_d   = '0;
         state_d = S_IDLE;
      end
   end

   assign STEP_REQ    = req_q;
   assign STEP_UP     = up_q;
   assign STEP_CNTSEL = CNTSEL;
   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign FAIL        = fail_q;
   assign BEST_START  = best_start_q;
   assign BEST_LEN    = best_len_q;
   assign POS         = pos_q;

endmodule
